loop_sequencer_arbiter: RTL and testbench

- Shares one registered loop-index engine (counter plus iteration strobe) between NREQ requesters.
- Each requester asks for a run of N iterations. The block grants the engine round-robin and steps the index 0..N-1, one per clock.
- It signals per-requester completion, and sits in front of blocks that consume the loop index.

---
 rtl/loop_sequencer_arbiter.sv | 128 ++++++++++++
 tb/tb_loop_sequencer_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer_arbiter.sv
// Round-robin arbiter in front of one shared loop-index engine: the granted
// requester gets its index stepped 0..N-1, one per clock, then a done pulse.
module loop_sequencer_arbiter #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*CNT_W-1:0]   req_count,
    input  logic                    abort,
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic                    iter_valid,
    output logic [CNT_W-1:0]        iter_index,
    output logic [NREQ-1:0]         done
);

    localparam int OW = $clog2(NREQ);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("loop_sequencer_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [OW-1:0]    owner, next_owner;
    logic [OW-1:0]    last_owner, next_last_owner;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [CNT_W-1:0] idx, next_idx;
    logic [CNT_W-1:0] last_idx;

    logic             win_found;
    logic [OW-1:0]    win;
    logic [CNT_W-1:0] win_count;
    int               cand;

    // Scan starts one past the previous owner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win       = '0;
        cand      = 0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = (int'(last_owner) + i) % NREQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win       = OW'(cand);
            end
        end
    end

    assign win_count = req_count[int'(win)*CNT_W +: CNT_W];
    assign last_idx  = cnt - CNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            cnt        <= '0;
            idx        <= '0;
        end else begin
            state      <= next_state;
            owner      <= next_owner;
            last_owner <= next_last_owner;
            cnt        <= next_cnt;
            idx        <= next_idx;
        end
    end

    always_comb begin
        next_state      = state;
        next_owner      = owner;
        next_last_owner = last_owner;
        next_cnt        = cnt;
        next_idx        = idx;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    next_owner = win;
                    next_cnt   = win_count;
                    next_idx   = '0;
                    next_state = (win_count != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // idx freezes on exit so iter_index keeps the last shown value.
                if (abort || idx == last_idx) begin
                    next_state = ST_DONE;
                end else begin
                    next_idx = idx + CNT_ONE;
                end
            end
            ST_DONE: begin
                next_state      = ST_IDLE;
                next_last_owner = owner;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs depend only on registered state; no input reaches them combinationally.
    always_comb begin
        grant = '0;
        done  = '0;
        if (state != ST_IDLE) begin
            grant[owner] = 1'b1;
        end
        if (state == ST_DONE) begin
            done[owner] = 1'b1;
        end
    end

    assign busy       = (state != ST_IDLE);
    assign iter_valid = (state == ST_RUN);
    assign iter_index = idx;

endmodule

// File: tb/tb_loop_sequencer_arbiter.sv
// Directed bench for loop_sequencer_arbiter with a scoreboard of expected
// iterations, grant starts and done pulses.
module tb_loop_sequencer_arbiter;

    localparam int NREQ  = 4;
    localparam int CNT_W = 8;
    localparam int W     = NREQ + CNT_W;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] req_count;
    logic                  abort;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  iter_valid;
    logic [CNT_W-1:0]      iter_index;
    logic [NREQ-1:0]       done;

    loop_sequencer_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_count  (req_count),
        .abort      (abort),
        .grant      (grant),
        .busy       (busy),
        .iter_valid (iter_valid),
        .iter_index (iter_index),
        .done       (done)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    logic [W-1:0]    exp_q[$];
    logic [NREQ-1:0] done_q[$];
    logic [NREQ-1:0] grant_q[$];
    logic [NREQ-1:0] prev_grant = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic set_count(input int k, input int v);
        req_count[k*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    // Queue the expected grant start, iterations and (optionally) done pulse.
    task automatic push_run(input int k, input int n_iter, input bit with_done);
        logic [NREQ-1:0]  oh;
        logic [CNT_W-1:0] ix;
        oh    = '0;
        oh[k] = 1'b1;
        grant_q.push_back(oh);
        for (int i = 0; i < n_iter; i++) begin
            ix = CNT_W'(i);
            exp_q.push_back({oh, ix});
        end
        if (with_done) done_q.push_back(oh);
    endtask

    // Hold requests until each owner's done pulse, then wait for idle.
    task automatic serve(input string tag, input int bound);
        int n;
        n = 0;
        while ((req != '0 || busy) && n < bound) begin
            step();
            n++;
            req = req & ~done;
        end
        check({tag, "_bounded"}, 32'(n < bound), 32'd1);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
            if (prev_grant != '0 && grant != '0)
                check("grant_no_switch", 32'(grant), 32'(prev_grant));
            if (grant != '0 && prev_grant == '0) begin
                check("grant_expected", 32'(grant_q.size() != 0), 32'd1);
                if (grant_q.size() != 0) check("grant_order", 32'(grant), 32'(grant_q.pop_front()));
            end
            if (iter_valid === 1'b1) begin
                check("iter_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("iter_owner_idx", 32'({grant, iter_index}), 32'(exp_q.pop_front()));
            end
            if (done != '0) begin
                check("done_expected", 32'(done_q.size() != 0), 32'd1);
                if (done_q.size() != 0) check("done_owner", 32'(done), 32'(done_q.pop_front()));
                check("done_matches_grant", 32'(done), 32'(grant));
                check("done_no_iter", 32'(iter_valid), 32'd0);
            end
            prev_grant = grant;
        end
    end

    initial begin
        int               nv;
        logic [CNT_W-1:0] last_ix;
        reset     = 1'b1;
        req       = '0;
        req_count = '0;
        abort     = 1'b0;
        repeat (3) step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(iter_valid), 32'd0);
        check("rst_index", 32'(iter_index), 32'd0);
        mon_en = 1'b1;
        reset  = 1'b0;
        step();

        // Single requester, three iterations.
        set_count(0, 3);
        req = 4'b0001;
        push_run(0, 3, 1'b1);
        step();
        check("t1_grant", 32'(grant), 32'b0001);
        check("t1_valid", 32'(iter_valid), 32'd1);
        check("t1_idx0", 32'(iter_index), 32'd0);
        step();
        step();
        step();
        check("t1_done", 32'(done), 32'b0001);
        check("t1_grant_held", 32'(grant), 32'b0001);
        check("t1_valid_low", 32'(iter_valid), 32'd0);
        check("t1_idx_hold", 32'(iter_index), 32'd2);
        req = '0;
        step();
        check("t1_grant_off", 32'(grant), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // Zero count: grant and done together, no iterations.
        set_count(1, 0);
        req = 4'b0010;
        push_run(1, 0, 1'b1);
        step();
        check("t2_grant", 32'(grant), 32'b0010);
        check("t2_done", 32'(done), 32'b0010);
        check("t2_busy", 32'(busy), 32'd1);
        req = '0;
        step();
        check("t2_grant_off", 32'(grant), 32'd0);
        check("t2_busy_off", 32'(busy), 32'd0);

        // All four requesting from a fresh pointer: order 0,1,2,3 then 0 again.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            set_count(k, 2);
            push_run(k, 2, 1'b1);
        end
        req = 4'b1111;
        serve("t3_all", 60);
        push_run(0, 2, 1'b1);
        req = 4'b0001;
        serve("t3_again", 20);

        // Abort while showing index 4.
        set_count(2, 10);
        req = 4'b0100;
        push_run(2, 5, 1'b1);
        repeat (5) step();
        check("t4_idx4", 32'(iter_index), 32'd4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_done", 32'(done), 32'b0100);
        check("t4_valid_low", 32'(iter_valid), 32'd0);
        check("t4_idx_hold", 32'(iter_index), 32'd4);
        req = '0;
        step();
        check("t4_busy_off", 32'(busy), 32'd0);

        // Abort seen only in IDLE must not cut the following run short.
        set_count(0, 2);
        req   = 4'b0001;
        abort = 1'b1;
        push_run(0, 2, 1'b1);
        step();
        abort = 1'b0;
        serve("t4_idle_abort", 20);

        // Reset mid-run: no done, and requester 0 regains top priority.
        set_count(0, 8);
        req = 4'b0001;
        push_run(0, 4, 1'b0);
        repeat (4) step();
        check("t5_idx3", 32'(iter_index), 32'd3);
        reset = 1'b1;
        req   = '0;
        step();
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_valid", 32'(iter_valid), 32'd0);
        check("t5_index", 32'(iter_index), 32'd0);
        reset = 1'b0;
        set_count(0, 1);
        set_count(1, 1);
        push_run(0, 1, 1'b1);
        push_run(1, 1, 1'b1);
        req = 4'b0011;
        serve("t5_after", 30);

        // Maximum count: 255 iterations ending at 254.
        set_count(3, 255);
        req = 4'b1000;
        push_run(3, 255, 1'b1);
        nv      = 0;
        last_ix = '0;
        for (int n = 0; n < 300 && req != '0; n++) begin
            step();
            if (iter_valid) begin
                nv++;
                last_ix = iter_index;
            end
            if (done != '0) req = '0;
        end
        check("t6_req_served", 32'(req), 32'd0);
        check("t6_count", 32'(nv), 32'd255);
        check("t6_last_idx", 32'(last_ix), 32'd254);
        step();
        step();

        check("end_iter_q_empty", 32'(exp_q.size()), 32'd0);
        check("end_done_q_empty", 32'(done_q.size()), 32'd0);
        check("end_grant_q_empty", 32'(grant_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
